opl_timer_bank: RTL and testbench

//  Parametrised OPL-style register front end and timer bank, successor to the fixed two-timer interface.

---
 rtl/opl_timer_pkg.sv | 27 ++
 rtl/opl_timer_unit.sv | 44 ++++
 rtl/opl_timer_bank.sv | 148 ++++++++++++++
 tb/tb_opl_timer_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/opl_timer_pkg.sv
// Shared definitions for the OPL timer bank: register index defaults,
// control-register bit positions and the per-timer resolution helper.
package opl_timer_pkg;

  typedef logic [7:0] opl_reg_t;

  localparam opl_reg_t REG_PRESET_BASE = 8'h02;
  localparam opl_reg_t REG_CTRL        = 8'h04;
  localparam int       CTRL_RST_BIT    = 7;
  localparam int       RES_BASE_DEF    = 80;

  // Control byte bit that starts timer i
  function automatic int start_bit(input int i);
    return i;
  endfunction

  // Control byte bit that masks timer i (mirrors the status bit position)
  function automatic int mask_bit(input int i);
    return 6 - i;
  endfunction

  // Resolution of timer i in microseconds; each timer is 4x coarser than the previous
  function automatic int res_us(input int i, input int base = RES_BASE_DEF);
    return base << (2 * i);
  endfunction

endpackage

// File: rtl/opl_timer_unit.sv
// One OPL-style 8-bit up-counting timer. A sub-counter divides the 1us tick
// down to the timer resolution; the main counter reloads from the preset on
// overflow, so a preset change only takes effect at the next reload.
module opl_timer_unit
  import opl_timer_pkg::*;
#(
  parameter int RES_US = 80,
  parameter int SUB_W  = 7
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  logic     start,
  input  opl_reg_t preset,
  output logic     ovf
);

  localparam logic [SUB_W-1:0] SUB_RELOAD = SUB_W'(RES_US - 1);

  logic [7:0]       r_cnt;
  logic [SUB_W-1:0] r_sub;

  // Overflow is the tick on which the sub-counter expires with the main counter at full scale
  assign ovf = ~rst & start & tick & (r_sub == '0) & (r_cnt == 8'hFF);

  // Stopped timers track the preset; running timers count on each 1us tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sub <= '0;
    end else if (!start) begin
      r_cnt <= preset;
      r_sub <= SUB_RELOAD;
    end else if (tick) begin
      if (r_sub != '0) begin
        r_sub <= r_sub - 1'b1;
      end else begin
        r_sub <= SUB_RELOAD;
        r_cnt <= (r_cnt == 8'hFF) ? preset : r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/opl_timer_bank.sv
// OPL-style register front end and timer bank. Captures index/data port
// writes, forwards data writes to the synth core, and runs 1..3 timers off an
// on-clock 1us tick enable, with status readback and an active-low IRQ.
// Build option OPL_TIMER_RST_BIT_EN: when defined, only a control write with
// bit 7 set clears the flags (and loads nothing else); when undefined, every
// control write clears the flags.
module opl_timer_bank
  import opl_timer_pkg::*;
#(
  parameter int       NUM_TIMERS  = 2,
  parameter int       CLK_DIV     = 14,
  parameter int       RES_BASE_US = 80,
  parameter opl_reg_t PRESET_BASE = REG_PRESET_BASE,
  parameter opl_reg_t CTRL_REG    = REG_CTRL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       addr,
  input  logic [7:0] din,
  input  logic       we,
  output logic [7:0] dout,
  output logic       irq_n,
  output logic       wr_stb,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data
);

  localparam int SUB_W = $clog2(RES_BASE_US << (2 * (NUM_TIMERS - 1)));
  localparam int DIV_W = $clog2(CLK_DIV);

  if (NUM_TIMERS < 1 || NUM_TIMERS > 3) begin : g_bad_num_timers
    $fatal(1, "opl_timer_bank: NUM_TIMERS must be 1..3");
  end
  if (int'(CTRL_REG) >= int'(PRESET_BASE) &&
      int'(CTRL_REG) < int'(PRESET_BASE) + NUM_TIMERS) begin : g_bad_ctrl_reg
    $fatal(1, "opl_timer_bank: CTRL_REG overlaps the preset registers");
  end

  logic                  r_we_q;
  opl_reg_t              r_wr_reg;
  opl_reg_t              r_wr_data;
  logic                  r_wr_stb;
  logic [DIV_W-1:0]      r_div;
  logic [NUM_TIMERS-1:0] r_flag;
  logic                  r_irq_n;

  logic                  w_wr;
  logic                  w_data_wr;
  logic                  w_ctrl_wr;
  logic                  w_ctrl_load;
  logic                  w_flag_clr;
  logic                  w_tick;
  logic [NUM_TIMERS-1:0] w_ovf;
  logic [NUM_TIMERS-1:0] w_mask;
  logic [2:0]            w_flag3;

  // A write is the rising edge of we, so a held-high we counts once
  assign w_wr        = we & ~r_we_q;
  assign w_data_wr   = w_wr & addr;
  assign w_ctrl_wr   = w_data_wr & (r_wr_reg == CTRL_REG);
  assign w_ctrl_load = w_ctrl_wr & ~din[CTRL_RST_BIT];
`ifdef OPL_TIMER_RST_BIT_EN
  assign w_flag_clr  = w_ctrl_wr & din[CTRL_RST_BIT];
`else
  assign w_flag_clr  = w_ctrl_wr;
`endif
  assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));

  // Bus side: edge detect, index latch and one-cycle strobe toward the synth core
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_q    <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_wr_stb  <= 1'b0;
    end else begin
      r_we_q   <= we;
      r_wr_stb <= w_data_wr;
      if (w_wr && !addr) r_wr_reg  <= din;
      if (w_data_wr)     r_wr_data <= din;
    end
  end

  // 1us tick divider: free-running 0..CLK_DIV-1
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_div <= '0;
    else               r_div <= r_div + 1'b1;
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_timer
    localparam int       SB  = start_bit(g);
    localparam int       MB  = mask_bit(g);
    localparam opl_reg_t IDX = opl_reg_t'(int'(PRESET_BASE) + g);

    opl_reg_t r_preset;
    logic     r_start;
    logic     r_mask;

    // Per-timer preset, start and mask captured from data-port writes
    always_ff @(posedge clk) begin
      if (rst) begin
        r_preset <= '0;
        r_start  <= 1'b0;
        r_mask   <= 1'b0;
      end else begin
        if (w_data_wr && (r_wr_reg == IDX)) r_preset <= din;
        if (w_ctrl_load) begin
          r_start <= din[SB];
          r_mask  <= din[MB];
        end
      end
    end

    assign w_mask[g] = r_mask;

    opl_timer_unit #(
      .RES_US (res_us(g, RES_BASE_US)),
      .SUB_W  (SUB_W)
    ) u_unit (
      .clk    (clk),
      .rst    (rst),
      .tick   (w_tick),
      .start  (r_start),
      .preset (r_preset),
      .ovf    (w_ovf[g])
    );
  end

  // Status flags: unmasked overflow sets, control write clears, set beats clear
  always_ff @(posedge clk) begin
    if (rst) r_flag <= '0;
    else     r_flag <= (r_flag & ~{NUM_TIMERS{w_flag_clr}}) | (w_ovf & ~w_mask);
  end

  // IRQ follows the flags one cycle later
  always_ff @(posedge clk) begin
    if (rst) r_irq_n <= 1'b1;
    else     r_irq_n <= ~|r_flag;
  end

  assign w_flag3 = 3'(r_flag);
  assign dout    = {|r_flag, w_flag3[0], w_flag3[1], w_flag3[2], 4'b0000};
  assign irq_n   = r_irq_n;
  assign wr_stb  = r_wr_stb;
  assign wr_reg  = r_wr_reg;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_opl_timer_bank.sv
// Directed bench for opl_timer_bank (2 timers, 14 clk per us, 80us base).
module tb_opl_timer_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       addr;
  logic [7:0] din;
  logic       we;
  logic [7:0] dout;
  logic       irq_n;
  logic       wr_stb;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;

  opl_timer_bank #(
    .NUM_TIMERS  (2),
    .CLK_DIV     (14),
    .RES_BASE_US (80),
    .PRESET_BASE (8'h02),
    .CTRL_REG    (8'h04)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .din     (din),
    .we      (we),
    .dout    (dout),
    .irq_n   (irq_n),
    .wr_stb  (wr_stb),
    .wr_reg  (wr_reg),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; addr = 1'b0; din = 8'h00; we = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // One port write; commits on the first posedge, returns one edge later
  task automatic wr(input logic a, input logic [7:0] d);
    addr = a; din = d; we = 1'b1;
    step();
    we = 1'b0;
    step();
  endtask

  task automatic wait_dout(input int limit, output int n);
    n = 0;
    while (dout == 8'h00 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic start_timer0();
    wr(1'b0, 8'h02); wr(1'b1, 8'hFF); wr(1'b0, 8'h04); wr(1'b1, 8'h01);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want %h", dout, 8'h00); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL rst_irq_n: got %b want 1", irq_n); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL rst_wr_stb: got %b want 0", wr_stb); end
    checks++; if (wr_reg !== 8'h00) begin errors++; $display("FAIL rst_wr_reg: got %h want %h", wr_reg, 8'h00); end
  endtask

  task automatic test_write();
    do_reset();
    addr = 1'b0; din = 8'h55; we = 1'b1;
    step();
    checks++; if (wr_reg !== 8'h55) begin errors++; $display("FAIL idx_latch: got %h want %h", wr_reg, 8'h55); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL idx_no_stb: got %b want 0", wr_stb); end
    din = 8'h66;
    step();
    checks++; if (wr_reg !== 8'h55) begin errors++; $display("FAIL held_we_once: got %h want %h", wr_reg, 8'h55); end
    we = 1'b0;
    step();
    addr = 1'b1; din = 8'hA7; we = 1'b1;
    step();
    checks++; if (wr_stb !== 1'b1) begin errors++; $display("FAIL data_stb: got %b want 1", wr_stb); end
    checks++; if (wr_data !== 8'hA7) begin errors++; $display("FAIL data_val: got %h want %h", wr_data, 8'hA7); end
    checks++; if (wr_reg !== 8'h55) begin errors++; $display("FAIL data_reg: got %h want %h", wr_reg, 8'h55); end
    step();
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL stb_one_cycle: got %b want 0", wr_stb); end
    we = 1'b0;
    step();
  endtask

  task automatic test_timer0();
    int n;
    do_reset();
    start_timer0();
    wait_dout(2000, n);
    // first tick lands 1..14 edges after start, then 79 more ticks of 14 clk
    checks++; if (n + 1 < 1107 || n + 1 > 1120) begin errors++; $display("FAIL t0_latency: got %0d want 1107..1120", n + 1); end
    checks++; if (dout !== 8'hC0) begin errors++; $display("FAIL t0_dout: got %h want %h", dout, 8'hC0); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL t0_irq_lag: got %b want 1", irq_n); end
    step();
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL t0_irq: got %b want 0", irq_n); end
  endtask

  task automatic test_timer1();
    int n;
    do_reset();
    wr(1'b0, 8'h03); wr(1'b1, 8'hFE); wr(1'b0, 8'h04); wr(1'b1, 8'h02);
    wait_dout(10000, n);
    checks++; if (n + 1 < 8947 || n + 1 > 8960) begin errors++; $display("FAIL t1_latency: got %0d want 8947..8960", n + 1); end
    checks++; if (dout !== 8'hA0) begin errors++; $display("FAIL t1_dout: got %h want %h", dout, 8'hA0); end
    wr(1'b1, 8'h80);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL t1_clear: got %h want %h", dout, 8'h00); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL t1_irq_release: got %b want 1", irq_n); end
    wait_dout(10000, n);
    checks++; if (n + 2 != 8960) begin errors++; $display("FAIL t1_period: got %0d want 8960", n + 2); end
    checks++; if (dout !== 8'hA0) begin errors++; $display("FAIL t1_dout2: got %h want %h", dout, 8'hA0); end
  endtask

  task automatic test_masked();
    int n;
    int bad;
    do_reset();
    wr(1'b0, 8'h02); wr(1'b1, 8'hFF); wr(1'b0, 8'h04); wr(1'b1, 8'h41);
    bad = 0;
    for (int k = 0; k < 2500; k++) begin
      step();
      if (dout !== 8'h00 || irq_n !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mask_quiet: got %0d bad cycles want 0", bad); end
    wr(1'b1, 8'h01);
    wait_dout(1300, n);
    checks++; if (dout !== 8'hC0) begin errors++; $display("FAIL mask_release: got %h want %h", dout, 8'hC0); end
  endtask

  task automatic test_set_wins();
    int n;
    do_reset();
    start_timer0();
    wait_dout(2000, n);
    wr(1'b1, 8'h80);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL sw_clear: got %h want %h", dout, 8'h00); end
    // next overflow is exactly 1120 edges after the first one
    for (int k = 2; k < 1119; k++) step();
    addr = 1'b1; din = 8'h80; we = 1'b1;
    step();
    we = 1'b0;
    checks++; if (dout !== 8'hC0) begin errors++; $display("FAIL set_wins: got %h want %h", dout, 8'hC0); end
    step();
    checks++; if (dout !== 8'hC0) begin errors++; $display("FAIL set_wins_hold: got %h want %h", dout, 8'hC0); end
  endtask

  task automatic test_rst_mid();
    int n;
    int bad;
    do_reset();
    start_timer0();
    wait_dout(2000, n);
    wr(1'b0, 8'h02); wr(1'b1, 8'h80); wr(1'b0, 8'h33);
    for (int k = 0; k < 1500; k++) step();
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL rm_pre_irq: got %b want 0", irq_n); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rm_dout: got %h want %h", dout, 8'h00); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL rm_irq_n: got %b want 1", irq_n); end
    checks++; if (wr_reg !== 8'h00) begin errors++; $display("FAIL rm_wr_reg: got %h want %h", wr_reg, 8'h00); end
    wr(1'b0, 8'h02); wr(1'b1, 8'hFF); wr(1'b0, 8'h04);
    bad = 0;
    for (int k = 0; k < 1300; k++) begin
      step();
      if (dout !== 8'h00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rm_no_restart: got %0d bad cycles want 0", bad); end
    wr(1'b1, 8'h01);
    wait_dout(1300, n);
    checks++; if (dout !== 8'hC0) begin errors++; $display("FAIL rm_fresh_start: got %h want %h", dout, 8'hC0); end
  endtask

  task automatic test_ctrl_clear();
    int n;
    logic [7:0] exp_after;
`ifdef OPL_TIMER_RST_BIT_EN
    exp_after = 8'hC0;
`else
    exp_after = 8'h00;
`endif
    do_reset();
    wr(1'b0, 8'h02); wr(1'b1, 8'hFF); wr(1'b0, 8'h03); wr(1'b1, 8'hFF);
    wr(1'b0, 8'h04); wr(1'b1, 8'h03);
    wait_dout(2000, n);
    checks++; if (dout !== 8'hC0) begin errors++; $display("FAIL cc_first: got %h want %h", dout, 8'hC0); end
    wr(1'b1, 8'h80);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL cc_clear80: got %h want %h", dout, 8'h00); end
    wait_dout(1300, n);
    checks++; if (dout !== 8'hC0) begin errors++; $display("FAIL cc_still_running: got %h want %h", dout, 8'hC0); end
    wr(1'b1, 8'h00);
    checks++; if (dout !== exp_after) begin errors++; $display("FAIL cc_ctrl00: got %h want %h", dout, exp_after); end
    for (int k = 0; k < 5000; k++) step();
    checks++; if (dout !== exp_after) begin errors++; $display("FAIL cc_stopped: got %h want %h", dout, exp_after); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_timer0();
    test_timer1();
    test_masked();
    test_set_wins();
    test_rst_mid();
    test_ctrl_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
